// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and halt signals shared by the arbiter and its environment.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              halt_req;
    logic              halted;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, halt_req,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, halted
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, halt_req,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, halted
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between a fetch and a data requester, with
// anti-starvation for fetch and a RUN/DRAIN/HALT quiesce sequence.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk1,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 2) ? $clog2(STARVE_MAX + 1) : 2;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    state_t            state;
    owner_t            owner;
    logic              owner_we;
    logic              halted_q;
    logic [CNT_W-1:0]  starve;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] dm_hold;

    logic issue_ok;
    logic fetch_forced;
    logic if_win;
    logic dm_win;
    logic if_valid_c;
    logic dm_valid_c;

    // Grants are gated by rst_n so nothing issues while reset is held.
    always_comb begin
        issue_ok     = rst_n && (state == RUN);
        fetch_forced = bus.if_req && (starve == STARVE_LIM);
        dm_win       = issue_ok && bus.dm_req && !fetch_forced;
        if_win       = issue_ok && bus.if_req && !dm_win;
        if_valid_c   = (owner == OWN_IF);
        dm_valid_c   = (owner == OWN_DM);
    end

    assign bus.if_gnt    = if_win;
    assign bus.dm_gnt    = dm_win;
    assign bus.mem_en    = if_win || dm_win;
    assign bus.mem_we    = dm_win && bus.dm_we;
    assign bus.mem_addr  = dm_win ? bus.dm_addr : bus.if_addr;
    assign bus.mem_wdata = dm_win ? bus.dm_wdata : '0;

    assign bus.if_valid  = if_valid_c;
    assign bus.dm_valid  = dm_valid_c;
    assign bus.if_rdata  = if_valid_c ? bus.mem_rdata : if_hold;
    assign bus.dm_rdata  = (dm_valid_c && !owner_we) ? bus.mem_rdata : dm_hold;
    assign bus.halted    = halted_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            halted_q <= 1'b0;
            owner    <= OWN_NONE;
            owner_we <= 1'b0;
            starve   <= '0;
            if_hold  <= '0;
            dm_hold  <= '0;
        end else begin
            case (state)
                RUN:     if (bus.halt_req) state <= DRAIN;
                DRAIN: begin
                    state    <= HALT;
                    halted_q <= 1'b1;
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase

            owner    <= if_win ? OWN_IF : (dm_win ? OWN_DM : OWN_NONE);
            owner_we <= dm_win && bus.dm_we;

            if (bus.if_req && !if_win)
                starve <= (starve == STARVE_LIM) ? starve : starve + 1'b1;
            else
                starve <= '0;

            // Capture returned data so rdata holds once valid drops.
            if (if_valid_c)
                if_hold <= bus.mem_rdata;
            if (dm_valid_c && !owner_we)
                dm_hold <= bus.mem_rdata;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory word-address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, consecutive fetch denials before fetch is forced to win.
REQ-004 SHALL have ports; one clock, reset asynchronous and active-low:
  clk1  in  1  single clock, all state updates on posedge
  rst_n  in  1  asynchronous active-low reset
  if_req  in  1  fetch requester wants a read
  if_addr  in  ADDR_W  fetch word address
  if_gnt  out  1  fetch access issued this cycle
  if_valid  out  1  if_rdata valid
  if_rdata  out  DATA_W  fetch read data
  dm_req  in  1  data requester wants an access
  dm_we  in  1  1 = store, 0 = load
  dm_addr  in  ADDR_W  data word address
  dm_wdata  in  DATA_W  store data
  dm_gnt  out  1  data access issued this cycle
  dm_valid  out  1  load data valid / store acknowledged
  dm_rdata  out  DATA_W  load data
  mem_en  out  1  memory access enable
  mem_we  out  1  memory write enable
  mem_addr  out  ADDR_W  memory address
  mem_wdata  out  DATA_W  memory write data
  mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after mem_en
  halt_req  in  1  stop issuing accesses
  halted  out  1  sticky, arbiter quiesced

Function
REQ-005 SHALL issue at most one memory access per cycle; a winner's gnt, mem_en, mem_we, mem_addr and mem_wdata SHALL be combinational in the same cycle.
REQ-006 SHALL keep mem_en, mem_we, if_gnt and dm_gnt at 0 when no requester wins.
REQ-007 Requesters hold req, addr, we and wdata stable until their gnt is seen; the arbiter SHALL NOT buffer requests.
REQ-008 Priority: data requester wins when both request, unless the starve counter equals STARVE_MAX, in which case fetch wins.
REQ-009 Starve counter: 2-bit minimum width; increments when if_req=1 and if_gnt=0; clears when if_gnt=1 or if_req=0; saturates at STARVE_MAX.
REQ-010 SHALL register the owner (IF, DM, none) and dm_we of each issued access; next cycle exactly one of if_valid/dm_valid pulses for one cycle.
REQ-011 if_rdata/dm_rdata SHALL equal mem_rdata when the matching valid=1; otherwise hold their last value.
REQ-012 A store SHALL produce dm_valid=1 the next cycle, with dm_rdata unchanged.
REQ-013 Throughput SHALL be one access per cycle back-to-back, no bubbles, for either requester.
REQ-014 Halt FSM states RUN, DRAIN, HALT; RUN->DRAIN on posedge with halt_req=1; DRAIN->HALT on the next posedge; HALT is terminal until reset.
REQ-015 In RUN the halt_req cycle itself SHALL still arbitrate normally; in DRAIN and HALT no gnt SHALL be issued.
REQ-016 In DRAIN the valid for the last RUN-cycle access SHALL still be delivered.
REQ-017 halted SHALL be 1 only in HALT.
REQ-018 halt_req in DRAIN or HALT SHALL be ignored.

Reset
REQ-019 While rst_n=0: state RUN, starve counter 0, owner none, if_valid=dm_valid=0, halted=0, if_rdata=dm_rdata=0.
REQ-020 While rst_n=0: gnt and mem_en/mem_we SHALL be 0 regardless of requests.
REQ-021 Reset asserted with an access outstanding SHALL drop its valid; no valid after reset release without a new grant.

Verification
REQ-022 Fetch only: if_req=1, if_addr=5, mem[5]=0xDEADBEEF -> if_gnt=1 same cycle, next cycle if_valid=1 with if_rdata=0xDEADBEEF.
REQ-023 Contention: if_req=dm_req=1 held 5 cycles, STARVE_MAX=3 -> grants DM,DM,DM,IF,DM; counter 1,2,3,0,1.
REQ-024 Store then load: dm store addr 10 data 0x12345678, next cycle load addr 10 -> dm_valid both cycles after, load dm_rdata=0x12345678.
REQ-025 Halt: fetch requesting every cycle, halt_req pulsed at cycle N -> gnt at N, none from N+1, if_valid at N+1, halted=1 from N+2, stays 1.
REQ-026 Reset mid-access: load granted, rst_n low before next edge -> dm_valid never pulses; after release all outputs at reset values.
REQ-027 Idle: no requests 10 cycles -> mem_en=0, both valids 0, counter 0.
